// File: rtl/ps2_letter_decoder_pkg.sv
// Shared constants, state types and the Set-2 letter lookup for the PS/2
// letter decoder. Optional feature macro: PS2_PARITY_CHECK_EN (odd parity check).
package ps2_pkg;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX   = 8'hE0;

  // Held-key register value meaning "no key currently held"; never a valid index.
  localparam logic [4:0] LETTER_NONE  = 5'd31;

  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;

  typedef enum logic [1:0] {
    PFX_NORMAL,
    PFX_BRK,
    PFX_EXT,
    PFX_EXT_BRK
  } pfx_state_t;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } letter_lu_t;

  // Scancode to letter index; hit=0 for anything that is not A..Z.
  function automatic letter_lu_t ps2_lookup(input logic [7:0] code);
    letter_lu_t r;
    r.hit = 1'b1;
    r.idx = 5'd0;
    case (code)
      SC_A: r.idx = 5'd0;   SC_B: r.idx = 5'd1;   SC_C: r.idx = 5'd2;
      SC_D: r.idx = 5'd3;   SC_E: r.idx = 5'd4;   SC_F: r.idx = 5'd5;
      SC_G: r.idx = 5'd6;   SC_H: r.idx = 5'd7;   SC_I: r.idx = 5'd8;
      SC_J: r.idx = 5'd9;   SC_K: r.idx = 5'd10;  SC_L: r.idx = 5'd11;
      SC_M: r.idx = 5'd12;  SC_N: r.idx = 5'd13;  SC_O: r.idx = 5'd14;
      SC_P: r.idx = 5'd15;  SC_Q: r.idx = 5'd16;  SC_R: r.idx = 5'd17;
      SC_S: r.idx = 5'd18;  SC_T: r.idx = 5'd19;  SC_U: r.idx = 5'd20;
      SC_V: r.idx = 5'd21;  SC_W: r.idx = 5'd22;  SC_X: r.idx = 5'd23;
      SC_Y: r.idx = 5'd24;  SC_Z: r.idx = 5'd25;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_letter_decoder_if.sv
// Letter event bus from the PS/2 decoder to the game-control FSM.
interface ps2_letter_decoder_if;
  logic [4:0] letter;
  logic       letter_valid;
  logic       key_release;
  logic       frame_err;

  modport master (output letter, letter_valid, key_release, frame_err);
  modport slave  (input  letter, letter_valid, key_release, frame_err);
endinterface

// File: rtl/ps2_letter_decoder_frame_rx.sv
// PS/2 device-to-host frame receiver: line synchroniser, falling-edge detect,
// 11-bit deserialiser, mid-frame timeout and (PS2_PARITY_CHECK_EN) odd parity.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbdclk_i,
  input  logic       kbddat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] kc_sync_q, kd_sync_q;
  logic                   kc_prev_q;
  logic                   edge_q, dat_q;

  rx_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] byte_q, byte_d;
  logic [TW-1:0] to_q, to_d;
  logic       bv_q, bv_d;
  logic       fe_q, fe_d;
  logic       kc_s, kd_s;

  assign kc_s = kc_sync_q[SYNC_STAGES-1];
  assign kd_s = kd_sync_q[SYNC_STAGES-1];

  // Synchronise both lines (idle high) and register the falling edge of kbdclk
  // together with the data value seen at that point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kc_sync_q <= '1;
      kd_sync_q <= '1;
      kc_prev_q <= 1'b1;
      edge_q    <= 1'b0;
      dat_q     <= 1'b1;
    end else begin
      kc_sync_q <= {kc_sync_q[SYNC_STAGES-2:0], kbdclk_i};
      kd_sync_q <= {kd_sync_q[SYNC_STAGES-2:0], kbddat_i};
      kc_prev_q <= kc_s;
      edge_q    <= kc_prev_q & ~kc_s;
      dat_q     <= kd_s;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  // Parity bit is only kept when it is going to be checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  // Receive FSM state, shift register and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= 4'd0;
      sh_q    <= 8'd0;
      byte_q  <= 8'd0;
      to_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      byte_q  <= byte_d;
      to_q    <= to_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  // Bit slots in SHIFT: 0..7 data (LSB first), 8 parity, 9 stop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    byte_d  = byte_q;
    to_d    = '0;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d   = par_q;
`endif
    case (state_q)
      RX_IDLE: begin
        // A high data bit on an edge is not a start bit; ignore it.
        if (edge_q && !dat_q) begin
          state_d = RX_SHIFT;
          cnt_d   = 4'd0;
        end
      end
      RX_SHIFT: begin
        if (edge_q) begin
          if (cnt_q < 4'd8) begin
            sh_d  = {dat_q, sh_q[7:1]};
            cnt_d = cnt_q + 4'd1;
          end else if (cnt_q == 4'd8) begin
`ifdef PS2_PARITY_CHECK_EN
            par_d = dat_q;
`endif
            cnt_d = cnt_q + 4'd1;
          end else begin
            state_d = RX_IDLE;
            cnt_d   = 4'd0;
            if (dat_q) begin
`ifdef PS2_PARITY_CHECK_EN
              if (^{sh_q, par_q}) begin
                bv_d   = 1'b1;
                byte_d = sh_q;
              end else begin
                fe_d = 1'b1;
              end
`else
              bv_d   = 1'b1;
              byte_d = sh_q;
`endif
            end else begin
              fe_d = 1'b1;
            end
          end
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          // Keyboard stalled mid-frame: drop the partial byte.
          state_d = RX_IDLE;
          cnt_d   = 4'd0;
          fe_d    = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = bv_q;
  assign frame_err_o  = fe_q;

endmodule

// File: rtl/ps2_letter_decoder.sv
// PS/2 letter decoder top: frame receiver, Set-2 prefix FSM (F0/E0), A..Z
// lookup and typematic-repeat suppression. Optional macro PS2_PARITY_CHECK_EN
// enables odd-parity checking in the frame receiver.
module ps2_letter_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kbdclk,
  input  logic kbddat,
  ps2_letter_decoder_if.master evt
);

  logic [7:0] rx_byte;
  logic       rx_bv;
  logic       rx_fe;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .kbdclk_i     (kbdclk),
    .kbddat_i     (kbddat),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_bv),
    .frame_err_o  (rx_fe)
  );

  pfx_state_t pfx_q, pfx_d;
  logic [4:0] held_q, held_d;
  logic [4:0] letter_q, letter_d;
  logic       lv_q, lv_d;
  logic       kr_q, kr_d;
  letter_lu_t lu;

  // Prefix state, held key and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfx_q    <= PFX_NORMAL;
      held_q   <= LETTER_NONE;
      letter_q <= 5'd0;
      lv_q     <= 1'b0;
      kr_q     <= 1'b0;
    end else begin
      pfx_q    <= pfx_d;
      held_q   <= held_d;
      letter_q <= letter_d;
      lv_q     <= lv_d;
      kr_q     <= kr_d;
    end
  end

  // Prefix FSM advances once per received byte; extended keys are swallowed.
  always_comb begin
    pfx_d    = pfx_q;
    held_d   = held_q;
    letter_d = letter_q;
    lv_d     = 1'b0;
    kr_d     = 1'b0;
    lu       = ps2_lookup(rx_byte);
    if (rx_bv) begin
      case (pfx_q)
        PFX_NORMAL: begin
          if (rx_byte == BREAK_PREFIX) begin
            pfx_d = PFX_BRK;
          end else if (rx_byte == EXT_PREFIX) begin
            pfx_d = PFX_EXT;
          end else if (lu.hit && (lu.idx != held_q)) begin
            // A make for the key already held is typematic repeat.
            letter_d = lu.idx;
            lv_d     = 1'b1;
            held_d   = lu.idx;
          end
        end
        PFX_BRK: begin
          pfx_d = PFX_NORMAL;
          if (lu.hit) begin
            letter_d = lu.idx;
            kr_d     = 1'b1;
            if (lu.idx == held_q) held_d = LETTER_NONE;
          end
        end
        PFX_EXT: begin
          pfx_d = (rx_byte == BREAK_PREFIX) ? PFX_EXT_BRK : PFX_NORMAL;
        end
        PFX_EXT_BRK: pfx_d = PFX_NORMAL;
        default:     pfx_d = PFX_NORMAL;
      endcase
    end
  end

  assign evt.letter       = letter_q;
  assign evt.letter_valid = lv_q;
  assign evt.key_release  = kr_q;
  assign evt.frame_err    = rx_fe;

endmodule
